// File: rtl/spi_master_mc_if.sv
// Handshake and pad signals of the SPI master, grouped so the controller side
// and the pad side each see one bundle.
interface spi_master_mc_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 16
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic [DATA_W-1:0] din_i;
  logic              start_i;
  logic [CS_W-1:0]   cs_sel_i;
  logic              cpol_i;
  logic              cpha_i;
  logic              lsb_first_i;
  logic [DIV_W-1:0]  dvsr_i;
  logic              miso_i;
  logic [DATA_W-1:0] dout_o;
  logic              spi_done_tick_o;
  logic              ready_o;
  logic              sclk_o;
  logic              mosi_o;
  logic [NUM_CS-1:0] ss_n_o;

  modport master (
    input  din_i, start_i, cs_sel_i, cpol_i, cpha_i, lsb_first_i, dvsr_i, miso_i,
    output dout_o, spi_done_tick_o, ready_o, sclk_o, mosi_o, ss_n_o
  );

  modport slave (
    output din_i, start_i, cs_sel_i, cpol_i, cpha_i, lsb_first_i, dvsr_i, miso_i,
    input  dout_o, spi_done_tick_o, ready_o, sclk_o, mosi_o, ss_n_o
  );
endinterface

// File: rtl/spi_master_mc.sv
// Parametrised SPI master: configurable width, CPOL/CPHA, SCLK divider,
// bit order and one-hot active-low slave selects. All outputs registered.
module spi_master_mc #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  spi_master_mc_if.master bus
);
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, P0, P1, HOLD} state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  dvsr_q, dvsr_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [CS_W-1:0]   cs_q, cs_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] ss_n_q, ss_n_d;
  logic              last;

  // Equality against the latched divisor lets the counter reach 2^DIV_W-1 without wrapping early
  assign last = (cnt_q == dvsr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvsr_d  = dvsr_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cs_d    = cs_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    dout_d  = dout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (bus.start_i) begin
          state_d = SETUP;
          dvsr_d  = bus.dvsr_i;
          tx_d    = bus.din_i;
          cs_d    = bus.cs_sel_i;
          cpol_d  = bus.cpol_i;
          cpha_d  = bus.cpha_i;
          lsb_d   = bus.lsb_first_i;
        end
      end
      SETUP: begin
        cnt_d = last ? '0 : cnt_q + DIV_W'(1);
        if (last) state_d = P0;
      end
      P0: begin
        cnt_d = last ? '0 : cnt_q + DIV_W'(1);
        if (last) begin
          state_d = P1;
          rx_d    = lsb_q ? {bus.miso_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], bus.miso_i};
        end
      end
      P1: begin
        cnt_d = last ? '0 : cnt_q + DIV_W'(1);
        if (last) begin
          if (bit_q == BIT_W'(DATA_W-1)) begin
            state_d = HOLD;
          end else begin
            state_d = P0;
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = lsb_q ? (tx_q >> 1) : (tx_q << 1);
          end
        end
      end
      HOLD: begin
        cnt_d = last ? '0 : cnt_q + DIV_W'(1);
        if (last) begin
          state_d = IDLE;
          dout_d  = rx_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so the registers line up with it
    ready_d = (state_d == IDLE);
    case (state_d)
      IDLE:    sclk_d = bus.cpol_i;
      P0:      sclk_d = cpol_d ^ cpha_d;
      P1:      sclk_d = ~(cpol_d ^ cpha_d);
      default: sclk_d = cpol_d;
    endcase
    mosi_d = (state_d == IDLE) ? mosi_q : (lsb_d ? tx_d[0] : tx_d[DATA_W-1]);
    for (int i = 0; i < NUM_CS; i++) begin
      ss_n_d[i] = !((state_d != IDLE) && (cs_d == CS_W'(i)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvsr_q  <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cs_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvsr_q  <= dvsr_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cs_q    <= cs_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
    end
  end

  assign bus.dout_o          = dout_q;
  assign bus.spi_done_tick_o = done_q;
  assign bus.ready_o         = ready_q;
  assign bus.sclk_o          = sclk_q;
  assign bus.mosi_o          = mosi_q;
  assign bus.ss_n_o          = ss_n_q;
endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: two instances (4 selects/16-bit divider and
// 3 selects/4-bit divider) share stimulus and are compared cycle by cycle to a timeline model.
module tb_spi_master_mc;
  localparam int DW = 8;

  typedef struct packed {
    logic       sclk;
    logic       mosi;
    logic       ready;
    logic       done;
    logic [3:0] ss;
    logic [7:0] dout;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        start;
  logic [1:0]  cs_sel;
  logic        cpol, cpha, lsb;
  logic [15:0] dvsr;
  logic        miso;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_dout;

  always #5 clk = ~clk;

  spi_master_mc_if #(.DATA_W(8), .NUM_CS(4), .DIV_W(16)) bus_a ();
  spi_master_mc_if #(.DATA_W(8), .NUM_CS(3), .DIV_W(4))  bus_b ();

  assign bus_a.din_i = din;        assign bus_b.din_i = din;
  assign bus_a.start_i = start;    assign bus_b.start_i = start;
  assign bus_a.cs_sel_i = cs_sel;  assign bus_b.cs_sel_i = cs_sel;
  assign bus_a.cpol_i = cpol;      assign bus_b.cpol_i = cpol;
  assign bus_a.cpha_i = cpha;      assign bus_b.cpha_i = cpha;
  assign bus_a.lsb_first_i = lsb;  assign bus_b.lsb_first_i = lsb;
  assign bus_a.dvsr_i = dvsr;      assign bus_b.dvsr_i = dvsr[3:0];
  assign bus_a.miso_i = miso;      assign bus_b.miso_i = miso;

  spi_master_mc #(.DATA_W(8), .NUM_CS(4), .DIV_W(16)) u_a (.clk_i(clk), .rst_ni(rst_n), .bus(bus_a));
  spi_master_mc #(.DATA_W(8), .NUM_CS(3), .DIV_W(4))  u_b (.clk_i(clk), .rst_ni(rst_n), .bus(bus_b));

  // Expected outputs k cycles after the accept cycle: phase p = k/H walks
  // SETUP, then P0/P1 per bit, then HOLD, then the done cycle at k = (2*DW+2)*H.
  function automatic obs_t model(input int k, input int h, input int ncs, input logic [7:0] d,
                                 input logic [7:0] rxw, input int cs, input bit cp, input bit ch,
                                 input bit lb, input logic [7:0] dprev);
    obs_t e;
    int   n, p, b;
    n = (2*DW+2)*h;
    p = k / h;
    b = (p >= 1 && p <= 2*DW) ? (p-1)/2 : ((p == 0) ? 0 : DW-1);
    e.mosi = lb ? d[b] : d[DW-1-b];
    e.ss   = 4'hF;
    if (k < n && cs < ncs) e.ss[cs] = 1'b0;
    if (k >= n) begin
      e.ready = 1'b1; e.done = 1'b1; e.sclk = cp; e.dout = rxw;
    end else begin
      e.ready = 1'b0; e.done = 1'b0; e.dout = dprev;
      if (p == 0 || p == 2*DW+1) e.sclk = cp;
      else if (p % 2 == 1)       e.sclk = cp ^ ch;
      else                       e.sclk = ~(cp ^ ch);
    end
    return e;
  endfunction

  // Caller sits at a negedge; start goes high for the accept at the next posedge.
  task automatic run_xfer(input logic [7:0] d, input logic [7:0] rxw, input int cs, input bit cp,
                          input bit ch, input bit lb, input int dv, input int pulse_k,
                          input bit hold_start, output int done_k, output int rises,
                          output int mosi_hi, output logic [3:0] ss_and_a, output logic [3:0] ss_and_b);
    int h, n, b, p;
    logic [7:0] dprev;
    logic prev_sclk;
    obs_t oa, ob, ea, eb;
    h = dv + 1; n = (2*DW+2)*h; dprev = exp_dout;
    done_k = -1; rises = 0; mosi_hi = 0; ss_and_a = 4'hF; ss_and_b = 4'hF; prev_sclk = cp;
    din = d; cs_sel = cs[1:0]; cpol = cp; cpha = ch; lsb = lb; dvsr = dv[15:0]; start = 1'b1;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      oa = {bus_a.sclk_o, bus_a.mosi_o, bus_a.ready_o, bus_a.spi_done_tick_o, bus_a.ss_n_o, bus_a.dout_o};
      ob = {bus_b.sclk_o, bus_b.mosi_o, bus_b.ready_o, bus_b.spi_done_tick_o, 1'b1, bus_b.ss_n_o, bus_b.dout_o};
      ea = model(k, h, 4, d, rxw, cs, cp, ch, lb, dprev);
      eb = model(k, h, 3, d, rxw, cs, cp, ch, lb, dprev);
      checks++;
      if (oa !== ea) begin
        errors++;
        $display("FAIL xfer_a k=%0d got %h expected %h (sclk,mosi,ready,done,ss,dout)", k, oa, ea);
      end
      checks++;
      if (ob !== eb) begin
        errors++;
        $display("FAIL xfer_b k=%0d got %h expected %h (sclk,mosi,ready,done,ss,dout)", k, ob, eb);
      end
      if (oa.done && done_k < 0) done_k = k;
      if (oa.sclk && !prev_sclk) rises++;
      prev_sclk = oa.sclk;
      if (oa.mosi) mosi_hi++;
      ss_and_a &= oa.ss;
      ss_and_b &= ob.ss;
      if (k < n) begin
        // Slave drives each bit for its whole bit window; busy-time inputs are scrambled
        p = k / h;
        b = (p >= 1 && p <= 2*DW) ? (p-1)/2 : ((p == 0) ? 0 : DW-1);
        miso   = lb ? rxw[b] : rxw[DW-1-b];
        start  = hold_start || (k == pulse_k);
        din    = 8'($urandom);
        cs_sel = 2'($urandom);
        cpha   = 1'($urandom);
        lsb    = 1'($urandom);
        dvsr   = 16'($urandom_range(0, 15));
      end else if (!hold_start) begin
        start = 1'b0;
      end
    end
    exp_dout = rxw;
  endtask

  task automatic test_reset();
    obs_t oa, ob;
    rst_n = 1'b0; start = 1'b0; din = 8'hFF; cs_sel = 2'd0; cpol = 1'b1; cpha = 1'b0;
    lsb = 1'b0; dvsr = 16'd0; miso = 1'b1;
    repeat (3) @(negedge clk);
    oa = {bus_a.sclk_o, bus_a.mosi_o, bus_a.ready_o, bus_a.spi_done_tick_o, bus_a.ss_n_o, bus_a.dout_o};
    ob = {bus_b.sclk_o, bus_b.mosi_o, bus_b.ready_o, bus_b.spi_done_tick_o, 1'b1, bus_b.ss_n_o, bus_b.dout_o};
    checks++;
    if (oa !== 16'h2F00) begin errors++; $display("FAIL reset_a got %h expected %h", oa, 16'h2F00); end
    checks++;
    if (ob !== 16'h2F00) begin errors++; $display("FAIL reset_b got %h expected %h", ob, 16'h2F00); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.sclk_o !== 1'b1) begin errors++; $display("FAIL idle_sclk_tracks_cpol got %b expected 1", bus_a.sclk_o); end
    cpol = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.sclk_o !== 1'b0) begin errors++; $display("FAIL idle_sclk_tracks_cpol got %b expected 0", bus_a.sclk_o); end
    exp_dout = 8'h00;
  endtask

  task automatic test_mode0();
    int dk, r, mh; logic [3:0] sa, sb;
    // Loopback: the slave returns exactly what is transmitted
    run_xfer(8'hA5, 8'hA5, 0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b0, dk, r, mh, sa, sb);
    checks++; if (dk !== 18) begin errors++; $display("FAIL mode0_done_k got %0d expected 18", dk); end
    checks++; if (r !== 8) begin errors++; $display("FAIL mode0_rises got %0d expected 8", r); end
    checks++; if (bus_a.dout_o !== 8'hA5) begin errors++; $display("FAIL mode0_dout got %h expected a5", bus_a.dout_o); end
    checks++; if (sa !== 4'b1110) begin errors++; $display("FAIL mode0_ss got %b expected 1110", sa); end
    @(negedge clk);
  endtask

  task automatic test_mode3();
    int dk, r, mh; logic [3:0] sa, sb;
    run_xfer(8'h3C, 8'hC3, 1, 1'b1, 1'b1, 1'b0, 3, -1, 1'b0, dk, r, mh, sa, sb);
    checks++; if (dk !== 72) begin errors++; $display("FAIL mode3_done_k got %0d expected 72", dk); end
    checks++; if (r !== 8) begin errors++; $display("FAIL mode3_rises got %0d expected 8", r); end
    checks++; if (bus_a.dout_o !== 8'hC3) begin errors++; $display("FAIL mode3_dout got %h expected c3", bus_a.dout_o); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cs_select();
    int dk, r, mh; logic [3:0] sa, sb;
    run_xfer(8'h5A, 8'h96, 2, 1'b0, 1'b1, 1'b0, 1, -1, 1'b0, dk, r, mh, sa, sb);
    checks++; if (sa !== 4'b1011) begin errors++; $display("FAIL cs2_ss_a got %b expected 1011", sa); end
    checks++; if (sb !== 4'b1011) begin errors++; $display("FAIL cs2_ss_b got %b expected 1011", sb); end
    run_xfer(8'hC7, 8'h21, 3, 1'b1, 1'b0, 1'b0, 0, -1, 1'b0, dk, r, mh, sa, sb);
    checks++; if (sa !== 4'b0111) begin errors++; $display("FAIL cs3_ss_a got %b expected 0111", sa); end
    checks++; if (sb !== 4'b1111) begin errors++; $display("FAIL cs3_ss_b_out_of_range got %b expected 1111", sb); end
    checks++; if (bus_b.dout_o !== 8'h21) begin errors++; $display("FAIL cs3_dout_b got %h expected 21", bus_b.dout_o); end
  endtask

  task automatic test_lsb_first();
    int dk, r, mh; logic [3:0] sa, sb;
    run_xfer(8'h01, 8'h01, 0, 1'b0, 1'b0, 1'b1, 2, -1, 1'b0, dk, r, mh, sa, sb);
    // mosi high through SETUP and bit 0 only: 3 half-periods of 3 clocks
    checks++; if (mh !== 9) begin errors++; $display("FAIL lsb_mosi_high got %0d expected 9", mh); end
    checks++; if (bus_a.dout_o !== 8'h01) begin errors++; $display("FAIL lsb_dout got %h expected 01", bus_a.dout_o); end
    @(negedge clk);
  endtask

  task automatic test_busy_start_ignored();
    int dk, r, mh; logic [3:0] sa, sb; logic [7:0] d, rw;
    d = 8'($urandom); rw = 8'($urandom);
    run_xfer(d, rw, 1, 1'b0, 1'b1, 1'b1, 2, 20, 1'b0, dk, r, mh, sa, sb);
    checks++; if (dk !== 54) begin errors++; $display("FAIL busy_done_k got %0d expected 54", dk); end
    checks++; if (bus_a.dout_o !== rw) begin errors++; $display("FAIL busy_dout got %h expected %h", bus_a.dout_o, rw); end
    repeat (3) @(negedge clk);
    checks++; if (bus_a.ready_o !== 1'b1) begin errors++; $display("FAIL busy_not_queued got ready %b expected 1", bus_a.ready_o); end
  endtask

  task automatic test_back_to_back();
    int dk, r, mh; logic [3:0] sa, sb; logic [7:0] rw1, rw2;
    rw1 = 8'($urandom); rw2 = 8'($urandom);
    run_xfer(8'($urandom), rw1, 0, 1'b1, 1'b0, 1'b0, 1, -1, 1'b1, dk, r, mh, sa, sb);
    checks++; if (bus_a.dout_o !== rw1) begin errors++; $display("FAIL b2b_first_dout got %h expected %h", bus_a.dout_o, rw1); end
    checks++; if (bus_a.ss_n_o !== 4'hF) begin errors++; $display("FAIL b2b_gap_ss got %b expected 1111", bus_a.ss_n_o); end
    run_xfer(8'($urandom), rw2, 3, 1'b0, 1'b1, 1'b1, 0, -1, 1'b0, dk, r, mh, sa, sb);
    checks++; if (dk !== 18) begin errors++; $display("FAIL b2b_second_done_k got %0d expected 18", dk); end
    checks++; if (bus_a.dout_o !== rw2) begin errors++; $display("FAIL b2b_second_dout got %h expected %h", bus_a.dout_o, rw2); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int dk, r, mh, dv, cs; logic [3:0] sa, sb; logic [7:0] rw;
    for (int i = 0; i < 6; i++) begin
      rw = 8'($urandom); dv = $urandom_range(0, 3); cs = $urandom_range(0, 3);
      run_xfer(8'($urandom), rw, cs, 1'($urandom), 1'($urandom), 1'($urandom), dv,
               $urandom_range(0, 10), 1'b0, dk, r, mh, sa, sb);
      checks++; if (dk !== 18*(dv+1)) begin errors++; $display("FAIL rand%0d_done_k got %0d expected %0d", i, dk, 18*(dv+1)); end
      checks++; if (bus_b.dout_o !== rw) begin errors++; $display("FAIL rand%0d_dout_b got %h expected %h", i, bus_b.dout_o, rw); end
      if (i % 2 == 1) @(negedge clk);
    end
  endtask

  task automatic test_max_divider();
    int dk, r, mh; logic [3:0] sa, sb; logic [7:0] rw;
    rw = 8'($urandom);
    run_xfer(8'($urandom), rw, 2, 1'b1, 1'b0, 1'b0, 15, -1, 1'b0, dk, r, mh, sa, sb);
    checks++; if (dk !== 288) begin errors++; $display("FAIL maxdiv_done_k got %0d expected 288", dk); end
    checks++; if (bus_b.dout_o !== rw) begin errors++; $display("FAIL maxdiv_dout_b got %h expected %h", bus_b.dout_o, rw); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    obs_t oa, ob; int dones;
    din = 8'h5A; cs_sel = 2'd1; cpol = 1'b1; cpha = 1'b0; lsb = 1'b0; dvsr = 16'd1; start = 1'b1; miso = 1'b1;
    // k = 18 with H = 2 is the first cycle of bit 4
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    oa = {bus_a.sclk_o, bus_a.mosi_o, bus_a.ready_o, bus_a.spi_done_tick_o, bus_a.ss_n_o, bus_a.dout_o};
    ob = {bus_b.sclk_o, bus_b.mosi_o, bus_b.ready_o, bus_b.spi_done_tick_o, 1'b1, bus_b.ss_n_o, bus_b.dout_o};
    checks++; if (oa !== 16'h2F00) begin errors++; $display("FAIL midreset_a got %h expected %h", oa, 16'h2F00); end
    checks++; if (ob !== 16'h2F00) begin errors++; $display("FAIL midreset_b got %h expected %h", ob, 16'h2F00); end
    rst_n = 1'b1;
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus_a.spi_done_tick_o || bus_b.spi_done_tick_o) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midreset_no_done got %0d ticks expected 0", dones); end
    exp_dout = 8'h00;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_cs_select();
    test_lsb_first();
    test_busy_start_ignored();
    test_back_to_back();
    test_random();
    test_max_divider();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
Parametrised SPI master, successor to the fixed 8-bit mode-0 master. Adds configurable word width, runtime CPOL/CPHA selection, a programmable SCLK divider, MSB/LSB-first ordering, MISO capture and NUM_CS one-hot active-low slave selects. It sits between the register/sequencer logic (din_i/start_i handshake) and the SPI pads.

Parameters:
DATA_W, 8, bits per transfer (>=2)
NUM_CS, 4, number of slave-select outputs (>=1)
DIV_W, 16, width of the half-period divider input

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, synchronous, active-low
din_i  in  DATA_W  transmit word, sampled when start is accepted
start_i  in  1  transfer request, accepted only while ready_o=1
cs_sel_i  in  max(1,$clog2(NUM_CS))  slave index for this transfer
cpol_i  in  1  SCLK idle level
cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first_i  in  1  1: LSB shifted first
dvsr_i  in  DIV_W  SCLK half-period = dvsr_i+1 clk cycles
miso_i  in  1  serial input
dout_o  out  DATA_W  received word
spi_done_tick_o  out  1  one-cycle pulse at transfer completion
ready_o  out  1  idle, can accept start
sclk_o  out  1  SPI clock
mosi_o  out  1  serial output
ss_n_o  out  NUM_CS  active-low slave selects

Behaviour:
- All outputs registered. Reset (rst_ni=0 at posedge): state IDLE, ready_o=1, ss_n_o all 1, sclk_o=0, mosi_o=0, dout_o=0, spi_done_tick_o=0, counters cleared. Reset mid-transfer aborts immediately; no done tick.
- H = dvsr_i+1, latched together with din_i, cs_sel_i, cpol_i, cpha_i and lsb_first_i when start is accepted. All are frozen for the whole transfer.
- In IDLE, sclk_o tracks cpol_i, registered every cycle.
- FSM states: IDLE, SETUP, P0, P1, HOLD.
  - IDLE: ready_o=1. A start_i=1 sample at cycle T moves to SETUP at T+1 with ready_o=0.
  - SETUP: H cycles. Selected ss_n_o bit is 0. sclk_o = CPOL. mosi_o = first bit (MSB, or LSB if lsb_first).
  - P0/P1: one half-period each, H cycles each. Repeat for DATA_W bits.
  - sclk_o during P0 = CPOL^CPHA; during P1 = ~(CPOL^CPHA).
  - MISO is sampled on the last clk cycle of P0, in both modes.
  - On the last cycle of P1, mosi_o advances to the next bit, or the FSM goes to HOLD after bit DATA_W-1.
  - HOLD: H cycles. ss still asserted, sclk_o = CPOL, mosi_o held.
  - Then IDLE: ss_n_o all 1, ready_o=1, dout_o = assembled word, spi_done_tick_o=1 for exactly that one cycle.
- Latency: done tick and ready_o rise at cycle T+1+(2*DATA_W+2)*H.
- Received bits are assembled in the same order as lsb_first selects for transmit. dout_o holds its value until the next completion.
- start_i while ready_o=0 is ignored; it is not queued.
- start_i in the done-tick cycle is accepted, giving back-to-back transfers. ss deasserts for at least that one cycle.
- cs_sel_i >= NUM_CS: transfer runs normally, but no ss_n_o bit asserts.
- dvsr_i=0: H=1, so SCLK = clk/2.
- The divider counter rolls at H-1 with no off-by-one, including at the maximum dvsr_i value (2^DIV_W-1).

Test Plan:
- Mode 0, DATA_W=8, dvsr=0, din=0xA5, MSB-first, miso looped to mosi, start at T:
  - 8 sclk rising edges with sclk period 2 clk.
  - ss_n_o[0] low from T+1 to T+18.
  - done tick and dout_o=0xA5 at T+19.
- Mode 3 (cpol=1, cpha=1), dvsr=3, din=0x3C, slave model returns 0xC3:
  - sclk idles high, period 8 clk.
  - dout_o=0xC3; done at T+1+18*4.
- cs_sel=2, NUM_CS=4 -> ss_n_o=4'b1011 during the transfer, 4'b1111 before and after. cs_sel=3 with NUM_CS=3 -> ss_n_o stays all 1.
- lsb_first=1, din=0x01 -> mosi_o high only during the first bit. miso bit stream 1,0,0,0,0,0,0,0 -> dout_o=0x01.
- start_i pulsed while busy -> no effect on din latch or timing. start_i held high through the done tick -> second transfer begins at done+1 with ss_n_o high for 1 cycle.
- rst_ni=0 at mid-transfer bit 4 -> next cycle ss_n_o=all 1, ready_o=1, sclk_o=0, dout_o=0, no done tick.
